// File: rtl/mem_access_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit_pkg : opcodes and access-size codes for the MEM stage    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_access_unit_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [1:0] size_t;

  localparam opcode_t EXE_LB  = 6'b100000;
  localparam opcode_t EXE_LH  = 6'b100001;
  localparam opcode_t EXE_LW  = 6'b100011;
  localparam opcode_t EXE_LBU = 6'b100100;
  localparam opcode_t EXE_LHU = 6'b100101;
  localparam opcode_t EXE_SB  = 6'b101000;
  localparam opcode_t EXE_SH  = 6'b101001;
  localparam opcode_t EXE_SW  = 6'b101011;

  localparam size_t SIZE_B = 2'd0;
  localparam size_t SIZE_H = 2'd1;
  localparam size_t SIZE_W = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit_if : sram-like data bus with addr_ok/data_ok handshake   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_lane_sel.sv
// +--------------------------------------------------------------------------+
// | mem_lane_sel : op decode, alignment check, byte-lane steering, extension |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_lane_sel
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int LB     = $clog2(LANES)
) (
  input  logic [5:0]        op,
  input  logic [LB-1:0]     off,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_load,
  output logic              is_store,
  output logic              misaligned,
  output logic [1:0]        size,
  output logic [LANES-1:0]  wstrb,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [31:0]       rdata_ext
);

  logic        sign_ext;
  logic [31:0] word;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SIZE_B;
    case (op)
      EXE_LB:  begin is_load  = 1'b1; sign_ext = 1'b1; end
      EXE_LBU: begin is_load  = 1'b1; end
      EXE_LH:  begin is_load  = 1'b1; sign_ext = 1'b1; size = SIZE_H; end
      EXE_LHU: begin is_load  = 1'b1; size = SIZE_H; end
      EXE_LW:  begin is_load  = 1'b1; size = SIZE_W; end
      EXE_SB:  begin is_store = 1'b1; end
      EXE_SH:  begin is_store = 1'b1; size = SIZE_H; end
      EXE_SW:  begin is_store = 1'b1; size = SIZE_W; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      case (size)
        SIZE_W:  misaligned = (off[1:0] != 2'b00);
        SIZE_H:  misaligned = off[0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Shift the addressed byte down to bit 0, then keep only the low word.
  assign word = 32'(rdata >> {off, 3'b000});

  always_comb begin
    case (size)
      SIZE_B:  rdata_ext = sign_ext ? {{24{word[7]}}, word[7:0]}
                                    : {24'b0, word[7:0]};
      SIZE_H:  rdata_ext = sign_ext ? {{16{word[15]}}, word[15:0]}
                                    : {16'b0, word[15:0]};
      default: rdata_ext = word;
    endcase
  end

  always_comb begin
    wstrb = '0;
    if (is_store) begin
      case (size)
        SIZE_B:  wstrb = LANES'(1)     << off;
        SIZE_H:  wstrb = LANES'(2'b11) << off;
        default: wstrb = LANES'(4'hF)  << off;
      endcase
    end
  end

  always_comb begin
    case (size)
      SIZE_B:  wdata_rep = {(DATA_W/8){wdata[7:0]}};
      SIZE_H:  wdata_rep = {(DATA_W/16){wdata[15:0]}};
      default: wdata_rep = {(DATA_W/32){wdata}};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store engine with flush-safe bus FSM    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       rdata_final,
  output logic              done,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_addr,
  mem_access_unit_if.master bus
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ       = 3'd1;
  localparam logic [2:0] ST_WAIT_DATA = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] rdata_q;
  logic        is_load, is_store, misaligned, issue, capture;
  logic [1:0]  size;
  logic [LANES-1:0]  wstrb;
  logic [DATA_W-1:0] wdata_rep;
  logic [31:0] rdata_ext;

  mem_lane_sel #(.DATA_W(DATA_W)) u_lane_sel (
    .op        (op),
    .off       (addr[LB-1:0]),
    .wdata     (wdata),
    .rdata     (bus.data_rdata),
    .is_load   (is_load),
    .is_store  (is_store),
    .misaligned(misaligned),
    .size      (size),
    .wstrb     (wstrb),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign issue   = mem_en && (is_load || is_store) && !misaligned && !flush;
  assign capture = (state == ST_WAIT_DATA) && bus.data_data_ok && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) rdata_q <= rdata_ext;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (issue) state_nxt = bus.data_addr_ok ? ST_WAIT_DATA : ST_REQ;
      ST_REQ:
        if (flush)                  state_nxt = ST_IDLE;
        else if (bus.data_addr_ok)  state_nxt = ST_WAIT_DATA;
      // A flushed transaction already on the bus must still be drained.
      ST_WAIT_DATA:
        if (bus.data_data_ok) state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)       state_nxt = ST_DRAIN;
      ST_DONE:
        state_nxt = ST_IDLE;
      ST_DRAIN:
        if (bus.data_data_ok) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.data_req = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE:      begin bus.data_req = issue;  stall = issue;  end
      ST_REQ:       begin bus.data_req = !flush; stall = !flush; end
      ST_WAIT_DATA: stall = 1'b1;
      ST_DONE:      done  = !flush;
      ST_DRAIN:     stall = 1'b1;
      default:      ;
    endcase
  end

  assign adel     = mem_en && is_load  && misaligned;
  assign ades     = mem_en && is_store && misaligned;
  assign bad_addr = misaligned ? addr : pc;

  assign rdata_final    = rdata_q;
  assign bus.data_wr    = is_store;
  assign bus.data_size  = size;
  assign bus.data_addr  = {addr[ADDR_W-1:LB], {LB{1'b0}}};
  assign bus.data_wstrb = wstrb;
  assign bus.data_wdata = wdata_rep;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench, 32- and 64-bit units  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk, rst;
  int   total, bad;

  logic        mem_en, flush;
  logic [5:0]  op;
  logic [31:0] pc, addr, wdata;
  logic        stall, done, adel, ades;
  logic [31:0] rdata_final, bad_addr;

  logic        mem_en64, flush64;
  logic [5:0]  op64;
  logic [31:0] pc64, addr64, wdata64;
  logic        stall64, done64, adel64, ades64;
  logic [31:0] rdata_final64, bad_addr64;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .op(op), .pc(pc), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .rdata_final(rdata_final),
    .done(done), .adel(adel), .ades(ades), .bad_addr(bad_addr), .bus(bus32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .mem_en(mem_en64), .op(op64), .pc(pc64), .addr(addr64),
    .wdata(wdata64), .flush(flush64), .stall(stall64), .rdata_final(rdata_final64),
    .done(done64), .adel(adel64), .ades(ades64), .bad_addr(bad_addr64), .bus(bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int req_cnt, stall_cnt, stall_run, done_cnt;
  logic run_alive;
  logic [31:0] got_rdata;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; mem_en = 0; flush = 0; op = '0; pc = 32'h400; addr = '0; wdata = '0;
    bus32.data_addr_ok = 0; bus32.data_data_ok = 0; bus32.data_rdata = '0;
    mem_en64 = 0; flush64 = 0; op64 = '0; pc64 = 32'h800; addr64 = '0; wdata64 = '0;
    bus64.data_addr_ok = 0; bus64.data_data_ok = 0; bus64.data_rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_req",   bus32.data_req, 0);
    chk("reset_done",  done, 0);
    chk("reset_stall", stall, 0);
    chk("reset_rdata", rdata_final, 0);
    chk("reset_adel_ades", {adel, ades}, 0);

    // LB at 0x1003: addr_ok now, data_ok next cycle, done the cycle after
    mem_en = 1; op = EXE_LB; addr = 32'h1003; bus32.data_addr_ok = 1;
    #1;
    chk("lb_req",   bus32.data_req, 1);
    chk("lb_stall0", stall, 1);
    chk("lb_addr",  bus32.data_addr, 32'h1000);
    chk("lb_size_wr_strb", {bus32.data_size, bus32.data_wr, bus32.data_wstrb}, {2'd0, 1'b0, 4'h0});
    chk("lb_bad_addr_pc", bad_addr, 32'h400);
    step();
    bus32.data_addr_ok = 0; bus32.data_data_ok = 1; bus32.data_rdata = 32'h80FF_0000;
    #1;
    chk("lb_stall1", stall, 1);
    chk("lb_wait_req_done", {bus32.data_req, done}, 0);
    step();
    bus32.data_data_ok = 0; bus32.data_rdata = 32'h0;
    #1;
    chk("lb_done",  done, 1);
    chk("lb_stall2", stall, 0);
    chk("lb_rdata", rdata_final, 32'hFFFF_FF80);
    mem_en = 0;
    step();
    chk("lb_done_pulse", done, 0);

    // SH at 0x2002
    mem_en = 1; op = EXE_SH; addr = 32'h2002; wdata = 32'h1234_ABCD; bus32.data_addr_ok = 1;
    #1;
    chk("sh_wstrb", bus32.data_wstrb, 4'b1100);
    chk("sh_wdata", bus32.data_wdata, 32'hABCD_ABCD);
    chk("sh_size_wr_req", {bus32.data_size, bus32.data_wr, bus32.data_req}, {2'd1, 1'b1, 1'b1});
    step();
    bus32.data_addr_ok = 0; bus32.data_data_ok = 1;
    step();
    bus32.data_data_ok = 0;
    #1;
    chk("sh_done", done, 1);
    mem_en = 0;
    step();

    // Address errors
    mem_en = 1; op = EXE_LW; addr = 32'h3001;
    #1;
    chk("lw_adel", {adel, ades}, 2'b10);
    chk("lw_bad_addr", bad_addr, 32'h3001);
    chk("lw_fault_req_stall", {bus32.data_req, stall}, 0);
    op = EXE_SH;
    #1;
    chk("sh_ades", {adel, ades}, 2'b01);
    op = EXE_SB; addr = 32'h3001; mem_en = 0;
    #1;
    chk("sb_no_fault", {adel, ades, bad_addr}, {2'b00, 32'h400});

    // Non-memory op
    mem_en = 1; op = 6'b000000; addr = 32'h3000;
    #1;
    chk("nonmem_req_stall_done", {bus32.data_req, stall, done}, 0);
    mem_en = 0;
    step();

    // addr_ok held low 3 cycles, data_ok 2 cycles after addr_ok
    req_cnt = 0; stall_cnt = 0; stall_run = 0; done_cnt = 0; run_alive = 1; got_rdata = '0;
    op = EXE_LW; addr = 32'h4000;
    for (int i = 0; i < 10; i++) begin
      mem_en = (i <= 6);
      bus32.data_addr_ok = (i == 3);
      bus32.data_data_ok = (i == 5);
      bus32.data_rdata = (i == 5) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      req_cnt   += int'(bus32.data_req);
      stall_cnt += int'(stall);
      if (run_alive && stall) stall_run++;
      else run_alive = 0;
      if (done) begin
        done_cnt++;
        got_rdata = rdata_final;
      end
      step();
    end
    bus32.data_addr_ok = 0; bus32.data_data_ok = 0;
    chk("wait_req_cycles", req_cnt, 4);
    chk("wait_stall_total", stall_cnt, 6);
    chk("wait_stall_continuous", stall_run, 6);
    chk("wait_done_count", done_cnt, 1);
    chk("wait_rdata", got_rdata, 32'hDEAD_BEEF);

    // Flush in WAIT_DATA, drain, then the next load issues from IDLE
    mem_en = 1; op = EXE_LW; addr = 32'h5000; bus32.data_addr_ok = 1;
    #1;
    chk("fl_req", bus32.data_req, 1);
    step();
    bus32.data_addr_ok = 0; flush = 1; mem_en = 0;
    #1;
    chk("fl_wait_stall_done", {stall, done}, 2'b10);
    step();
    flush = 0; mem_en = 1; addr = 32'h6000;
    #1;
    chk("fl_drain_hold", {bus32.data_req, stall}, 2'b01);
    step();
    bus32.data_data_ok = 1; bus32.data_rdata = 32'hBAD0_BAD0;
    #1;
    chk("fl_drain_dataok", {bus32.data_req, stall, done}, 3'b010);
    step();
    bus32.data_data_ok = 0; bus32.data_addr_ok = 1;
    #1;
    chk("fl_new_issue", {bus32.data_req, done}, 2'b10);
    chk("fl_new_addr", bus32.data_addr, 32'h6000);
    step();
    bus32.data_addr_ok = 0; bus32.data_data_ok = 1; bus32.data_rdata = 32'h1122_3344;
    step();
    bus32.data_data_ok = 0;
    #1;
    chk("fl_new_done_rdata", {done, rdata_final}, {1'b1, 32'h1122_3344});
    mem_en = 0;
    step();

    // 64-bit: SW at lane offset 4 under flush (no request), then LHU at 0x7006
    mem_en64 = 1; op64 = EXE_SW; addr64 = 32'h7004; wdata64 = 32'hCAFE_F00D; flush64 = 1;
    #1;
    chk("w64_sw_wstrb", bus64.data_wstrb, 8'hF0);
    chk("w64_sw_wdata", bus64.data_wdata, 64'hCAFE_F00D_CAFE_F00D);
    chk("w64_flush_req_stall", {bus64.data_req, stall64}, 0);
    flush64 = 0; op64 = EXE_LHU; addr64 = 32'h7006; bus64.data_addr_ok = 1;
    #1;
    chk("w64_lhu_req_wstrb", {bus64.data_req, bus64.data_wstrb}, {1'b1, 8'h00});
    chk("w64_lhu_addr", bus64.data_addr, 32'h7000);
    step();
    bus64.data_addr_ok = 0; bus64.data_data_ok = 1; bus64.data_rdata = 64'h8001_5555_AAAA_7777;
    step();
    bus64.data_data_ok = 0;
    #1;
    chk("w64_lhu_done_rdata", {done64, rdata_final64}, {1'b1, 32'h0000_8001});
    mem_en64 = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
